// File: rtl/wb_unit.sv
// Writeback stage: registers ALU-class results onto the register-file write port
// and runs a single outstanding load handshake with a timeout.
module wb_unit #(
  parameter int TIMEOUT = 16,
  parameter int R0_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic [31:0] in_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy_mask,
  output logic        err,
  input  logic        err_clr
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [0:0] {
    IDLE,
    LOAD_WAIT
  } state_t;

  state_t          state, state_n;
  logic [4:0]      ld_rd;
  logic [CW-1:0]   cnt;
  logic            is_wb, is_load;
  logic            accept;
  logic            timeout_hit;

  function automatic logic suppressed(input logic [4:0] r);
    return (R0_ZERO != 0) && (r == 5'd0);
  endfunction

  always_comb begin
    is_wb   = 1'b0;
    is_load = 1'b0;
    case (in_opcode) inside
      6'd1, 6'd2, [6'd5:6'd20], 6'd23, 6'd24: is_wb   = 1'b1;
      6'd4:                                   is_load = 1'b1;
      default: ;
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign timeout_hit = (state == LOAD_WAIT) && !mem_ack && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (in_valid && is_load) state_n = LOAD_WAIT;
      LOAD_WAIT: if (mem_ack || timeout_hit) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // busy bit is derived from the FSM so it drops on ack/timeout and on reset
  always_comb begin
    in_ready  = (state == IDLE);
    mem_req   = (state == LOAD_WAIT);
    busy_mask = '0;
    if (state == LOAD_WAIT && !suppressed(ld_rd)) busy_mask[ld_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      mem_addr <= '0;
      ld_rd    <= '0;
      cnt      <= '0;
      err      <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      if (accept && is_wb && !suppressed(in_rd)) begin
        rf_we    <= 1'b1;
        rf_waddr <= in_rd;
        rf_wdata <= in_result;
      end
      if (accept && is_load) begin
        ld_rd    <= in_rd;
        mem_addr <= in_addr;
        cnt      <= '0;
      end
      if (state == LOAD_WAIT) begin
        if (mem_ack) begin
          if (!suppressed(ld_rd)) begin
            rf_we    <= 1'b1;
            rf_waddr <= ld_rd;
            rf_wdata <= mem_rdata;
          end
        end else if (!timeout_hit) begin
          cnt <= cnt + 1'b1;
        end
      end
      if (timeout_hit)  err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: table of single-cycle ops plus load, timeout and
// reset-during-load sequences.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic [31:0] in_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic        err;
  logic        err_clr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_unit #(.TIMEOUT(16), .R0_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_result(in_result), .in_addr(in_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_mask(busy_mask), .err(err), .err_clr(err_clr)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        we;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] addr);
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_result = res;
    in_addr   = addr;
  endtask

  task automatic run_timeout(input logic [4:0] rd, input logic [31:0] exp_busy);
    int n;
    drive(6'd4, rd, 32'h0, 32'h200);
    tick();
    in_valid = 1'b0;
    chk("to_busy", busy_mask, exp_busy);
    n = 0;
    while (mem_req && n < 40) begin
      chk("to_no_write", {31'd0, rf_we}, 32'd0);
      n++;
      tick();
    end
    chk("to_req_cycles", n, 16);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_busy_clr", busy_mask, 32'd0);
    chk("to_ready", {31'd0, in_ready}, 32'd1);
    chk("to_we", {31'd0, rf_we}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{6'd1,  5'd3,  32'h0000_00AA, 1'b1};
    vecs[1]  = '{6'd2,  5'd1,  32'h1111_0001, 1'b1};
    vecs[2]  = '{6'd10, 5'd2,  32'h2222_0002, 1'b1};
    vecs[3]  = '{6'd24, 5'd4,  32'h4444_0004, 1'b1};
    vecs[4]  = '{6'd3,  5'd5,  32'h5555_0005, 1'b0};
    vecs[5]  = '{6'h15, 5'd5,  32'h6666_0006, 1'b0};
    vecs[6]  = '{6'd19, 5'd0,  32'h7777_0007, 1'b0};
    vecs[7]  = '{6'd16, 5'd31, 32'h8888_0008, 1'b1};
    vecs[8]  = '{6'd0,  5'd6,  32'h9999_0009, 1'b0};
    vecs[9]  = '{6'd23, 5'd8,  32'hAAAA_000A, 1'b1};
    vecs[10] = '{6'd63, 5'd9,  32'hBBBB_000B, 1'b0};
    vecs[11] = '{6'd22, 5'd10, 32'hCCCC_000C, 1'b0};
    vecs[12] = '{6'd18, 5'd30, 32'hDDDD_000D, 1'b1};
    vecs[13] = '{6'd5,  5'd12, 32'hEEEE_000E, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_rd = '0;
    in_result = '0; in_addr = '0; mem_ack = 1'b0; mem_rdata = '0; err_clr = 1'b0;
    tick();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // back-to-back single-cycle ops
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].res, 32'h0);
      tick();
      chk($sformatf("v%0d_we", i), {31'd0, rf_we}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        chk($sformatf("v%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].rd});
        chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].res);
      end
      chk($sformatf("v%0d_req", i), {31'd0, mem_req}, 32'd0);
      chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("idle_we", {31'd0, rf_we}, 32'd0);
    chk("idle_hold_waddr", {27'd0, rf_waddr}, 32'd12);
    chk("idle_hold_wdata", rf_wdata, 32'hEEEE_000E);

    // LOAD rd=7, ack during third wait cycle
    drive(6'd4, 5'd7, 32'h0, 32'h100);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ld_req%0d", c), {31'd0, mem_req}, 32'd1);
      chk($sformatf("ld_addr%0d", c), mem_addr, 32'h100);
      chk($sformatf("ld_busy%0d", c), busy_mask, 32'h80);
      chk($sformatf("ld_ready%0d", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("ld_we%0d", c), {31'd0, rf_we}, 32'd0);
      if (c == 2) begin
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("ld_done_we", {31'd0, rf_we}, 32'd1);
    chk("ld_done_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("ld_done_wdata", rf_wdata, 32'hDEADBEEF);
    chk("ld_done_busy", busy_mask, 32'd0);
    chk("ld_done_ready", {31'd0, in_ready}, 32'd1);
    chk("ld_done_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("ld_after_we", {31'd0, rf_we}, 32'd0);

    // LOAD to r0: request issued, no busy bit, no write
    drive(6'd4, 5'd0, 32'h0, 32'h300);
    tick();
    in_valid = 1'b0;
    chk("ld0_req", {31'd0, mem_req}, 32'd1);
    chk("ld0_busy", busy_mask, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("ld0_we", {31'd0, rf_we}, 32'd0);
    chk("ld0_req_drop", {31'd0, mem_req}, 32'd0);

    // stray ack while idle is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("stray_ack_we", {31'd0, rf_we}, 32'd0);

    // timeout, then clear
    run_timeout(5'd9, 32'h200);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", {31'd0, err}, 32'd0);

    // err_clr held through a timeout: timeout wins at its edge
    err_clr = 1'b1;
    run_timeout(5'd11, 32'h800);
    err_clr = 1'b0;
    tick();
    chk("err_sticky", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared2", {31'd0, err}, 32'd0);

    // asynchronous reset during a load
    drive(6'd4, 5'd6, 32'h0, 32'h400);
    tick();
    in_valid = 1'b0;
    chk("rl_busy", busy_mask, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("rl_req", {31'd0, mem_req}, 32'd0);
    chk("rl_busy0", busy_mask, 32'd0);
    chk("rl_we", {31'd0, rf_we}, 32'd0);
    chk("rl_ready", {31'd0, in_ready}, 32'd1);
    chk("rl_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    chk("rl_late_we", {31'd0, rf_we}, 32'd0);
    chk("rl_late_wdata", rf_wdata, 32'd0);
    chk("rl_late_req", {31'd0, mem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_unit.md
Name: wb_unit

Overview:
- Writeback stage: receives a completed instruction (opcode, destination register, ALU result, load address) and produces the register-file write port.
- Acts as the destination side of the operand-select path; results computed from selected rs1/rs2 are written back to rd here.
- ALU-class ops write back with 1-cycle latency, fully pipelined.
- LOAD issues a memory read handshake, stalls upstream, and writes the returned data. STORE and undefined opcodes retire with no write.

Parameters:
- TIMEOUT, default 16: max cycles mem_req may stay high without mem_ack before the load is abandoned.
- R0_ZERO, default 1: when 1, writes to rd=0 are suppressed (rf_we stays 0).

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  unit can accept; a transfer occurs on an edge with in_valid&&in_ready.
- in_opcode  in  6  opcode (ADD=1, SUB=2, STORE=3, LOAD=4, MOVE=5, SGE..NOT=6..15, MOVEI=16, SLI=17, SRI=18, ADDI=19, SUBI=20, ADDF=23, MULF=24).
- in_rd  in  5  destination register index.
- in_result  in  32  ALU/FPU result.
- in_addr  in  32  load address.
- mem_req  out  1  memory read request.
- mem_addr  out  32  read address, stable while mem_req=1.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  32  read data.
- rf_we  out  1  register-file write enable (one-cycle pulse).
- rf_waddr  out  5  write index.
- rf_wdata  out  32  write data.
- busy_mask  out  32  bit i=1 while a load to register i is outstanding.
- err  out  1  sticky load-timeout flag.
- err_clr  in  1  synchronous clear of err.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; mem_req=0; mem_addr=0; rf_we=0; rf_waddr=0; rf_wdata=0; busy_mask=0; err=0; timeout counter=0. A load in flight is abandoned; no write occurs.
- Opcode classes:
  - WB = {1,2,5..20,23,24}.
  - LOAD = 4.
  - NOWB = STORE(3) and all other values, including 0, 21, 22, 25..63.
- State IDLE (in_ready=1):
  - Accept WB at edge N: rf_we=1, rf_waddr=in_rd, rf_wdata=in_result during cycle N+1. Back-to-back accepts give one write per cycle.
  - Accept LOAD at edge N: latch rd; mem_addr=in_addr; mem_req=1 from cycle N+1; busy_mask[rd]=1; counter=0; go LOAD_WAIT. rf_we=0 in N+1 unless a prior WB write is still pending.
  - Accept NOWB: consumed, rf_we=0 next cycle.
- State LOAD_WAIT (in_ready=0):
  - mem_req and mem_addr are held constant.
  - Edge with mem_ack=1:
    - mem_req drops to 0.
    - Next cycle: rf_we=1, rf_waddr=latched rd, rf_wdata=mem_rdata as sampled.
    - busy_mask[rd] clears at the same edge.
    - Go IDLE; in_ready=1 in that same next cycle.
  - Edge with mem_ack=0: counter increments.
  - When counter reaches TIMEOUT-1 with no ack:
    - mem_req=0, busy bit clears, err=1, no write.
    - Go IDLE.
  - mem_ack outside LOAD_WAIT is ignored.
- rf_we is a registered pulse and is deasserted in any cycle with no write. rf_waddr and rf_wdata hold their last values when rf_we=0.
- R0_ZERO=1 with rd=0: the instruction is accepted and handled normally (load still issues mem_req), but rf_we stays 0 and busy_mask[0] is never set.
- err_clr=1: clears err at the edge. If a timeout occurs at the same edge, the timeout wins and err=1.
- Reset asserted mid-load: all outputs return immediately to their reset values.

Test Plan:
- Reset release, then ADD rd=3 result=0x0000_00AA accepted at edge N -> cycle N+1: rf_we=1, rf_waddr=3, rf_wdata=0xAA; cycle N+2: rf_we=0.
- SUB rd=1, XOR rd=2, MULF rd=4 on 3 consecutive edges -> 3 consecutive rf_we pulses in order, with rf_waddr=1, 2, 4 and matching data.
- LOAD rd=7 addr=0x100, mem_ack after 3 cycles with rdata=0xDEADBEEF:
  - mem_req=1 and mem_addr=0x100 held for 3 cycles.
  - busy_mask=0x80 during the wait; in_ready=0.
  - After ack: rf_we=1, waddr=7, wdata=0xDEADBEEF, busy_mask=0, in_ready=1.
- STORE rd=5 and opcode 0x15 accepted -> no rf_we, no mem_req. ADDI rd=0 with R0_ZERO=1 -> no rf_we.
- LOAD rd=9, mem_ack never asserted, TIMEOUT=16:
  - mem_req drops after 16 cycles; err=1; busy_mask=0; no write.
  - err_clr=1 for one cycle -> err=0.
- LOAD rd=6 in LOAD_WAIT, rst_n pulsed low asynchronously mid-cycle -> mem_req, busy_mask and rf_we are 0 immediately; in_ready=1; no late write even if mem_ack arrives afterwards.
